// File: rtl/shift_add_mult8.sv
// Sequential unsigned W x W shift-and-add multiplier with valid/ready handshakes.
// Uses one external ripple-carry adder pass per multiplier bit (W cycles per product).
module shift_add_mult8 #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  output logic           add_cin,
  input  logic [W-1:0]   add_s,
  input  logic           add_cout
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_m;
  logic [W-1:0]  r_acc_hi;
  logic [W-1:0]  r_q;
  logic [CW-1:0] r_count;
  logic          w_accept;
  logic          w_last;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_count == CW'(W - 1));

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_p     = '0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (w_accept) w_next = RUN;
      end
      RUN: begin
        add_a = r_acc_hi;
        add_b = r_q[0] ? r_m : '0;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        // Product is only visible here, so an abandoned run never leaks a partial result.
        out_valid = 1'b1;
        out_p     = {r_acc_hi, r_q};
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_m      <= '0;
      r_acc_hi <= '0;
      r_q      <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_m      <= in_a;
            r_q      <= in_b;
            r_acc_hi <= '0;
            r_count  <= '0;
          end
        end
        RUN: begin
          // Adder carry-out becomes the accumulator MSB; the consumed multiplier bit drops off.
          {r_acc_hi, r_q} <= {add_cout, add_s, r_q[W-1:1]};
          r_count         <= r_count + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult8.sv
// Self-checking bench for shift_add_mult8: directed cases plus randomized traffic
// compared against plain a*b arithmetic, with the adder modelled behaviourally.
module tb_shift_add_mult8;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_cin;
  logic [W-1:0]   add_s;
  logic           add_cout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the downstream ripple-carry adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  shift_add_mult8 #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; stall = cycles out_ready stays low after out_valid rises.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                       input string tag, output logic cout_seen, output logic addb_nz);
    int n;
    int exp_p;
    exp_p     = int'(a) * int'(b);
    cout_seen = 1'b0;
    addb_nz   = 1'b0;
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check({tag, "_ready_bound"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      if (in_ready) check({tag, "_ready_in_run"}, 32'(in_ready), 32'd0);
      cout_seen = cout_seen | add_cout;
      addb_nz   = addb_nz | (add_b != '0);
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(W));
    check({tag, "_product"}, 32'(out_p), 32'(exp_p));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_a     = ~a;
      in_b     = 8'd9;
      step();
      check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_stall_p"}, 32'(out_p), 32'(exp_p));
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic cs;
    logic bz;
    int   exp_q[$];
    int   sent;
    int   got;
    int   cyc;
    int   exp_p;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_p", 32'(out_p), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    check("rst_add_cin", 32'(add_cin), 32'd0);
    rst = 1'b0;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    do_op(8'd13, 8'd11, 0, "basic", cs, bz);

    do_op(8'd255, 8'd255, 0, "carry", cs, bz);
    check("carry_cout_seen", 32'(cs), 32'd1);

    do_op(8'd0, 8'd200, 0, "zero_a", cs, bz);
    do_op(8'd200, 8'd0, 0, "zero_b", cs, bz);
    check("zero_b_addb_quiet", 32'(bz), 32'd0);

    do_op(8'd100, 8'd3, 5, "stall", cs, bz);
    step();
    check("stall_no_capture", 32'(in_ready), 32'd1);

    // Abort a run part way through with an asynchronous reset.
    in_a     = 8'd77;
    in_b     = 8'd91;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("abort_in_run", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_p", 32'(out_p), 32'd0);
    check("abort_add_a", 32'(add_a), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid2", 32'(out_valid), 32'd0);
    do_op(8'd6, 8'd7, 0, "after_abort", cs, bz);

    // Randomized traffic against a queue of expected products.
    sent = 0;
    got  = 0;
    cyc  = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    while (got < 200 && cyc < 20000) begin
      if (!in_valid && sent < 200 && ($urandom_range(0, 2) != 0)) begin
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) begin
        exp_q.push_back(int'(in_a) * int'(in_b));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_output", 32'(out_p), 32'hFFFF_FFFF);
        end else begin
          exp_p = exp_q.pop_front();
          check("rand_product", 32'(out_p), 32'(exp_p));
        end
        got++;
      end
      step();
      if (in_valid && exp_q.size() > 0 && sent > 0 && !in_ready && out_valid == 1'b0) begin
        in_valid = 1'b0;
      end
      cyc++;
    end
    check("rand_received", 32'(got), 32'd200);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
